lcd_8080_byte_writer: RTL and testbench
=======================================

Name: lcd_8080_byte_writer

Overview:
- Avalon-ST sink directly downstream of the 24-to-8-bit LCD format adapter.
- Converts each 8-bit pixel-byte packet into an 8080-style parallel write burst to the LCD controller.
- Each packet becomes one RAMWR command byte (DC low) followed by data bytes (DC high), all under a single CS assertion.
- Drives the LCD pins with programmable WR strobe timing.

Parameters:
- WR_LOW_CYCLES, 2, clocks lcd_wr_n is held low per byte (>=1).
- WR_HIGH_CYCLES, 2, clocks lcd_wr_n is held high after each low phase (>=1).
- CS_SETUP_CYCLES, 1, clocks between lcd_cs_n falling and the first WR low (>=1).
- CMD_RAMWR, 8'h2C, command byte issued at the start of every packet.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_ready  out  1  sink ready.
- in_valid  in  1  beat valid.
- in_data  in  8  pixel byte.
- in_startofpacket  in  1  first beat of frame.
- in_endofpacket  in  1  last beat of frame.
- in_empty  in  1  on an EOP beat, 1 = byte carries no data.
- lcd_cs_n  out  1  chip select, active low.
- lcd_dc  out  1  0 = command, 1 = data.
- lcd_wr_n  out  1  write strobe; LCD latches on the rising edge.
- lcd_rd_n  out  1  constant 1.
- lcd_data  out  8  parallel bus.
- busy  out  1  high in any state other than IDLE.
- proto_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async, reset_n low): state IDLE, all counters 0, byte/EOP/empty latches cleared. Outputs: lcd_cs_n=1, lcd_dc=1, lcd_wr_n=1, lcd_rd_n=1, lcd_data=0, busy=0, proto_err=0, in_ready=0 while reset_n is low.
- Reset asserted mid-burst aborts immediately. CS rises asynchronously and no partial strobe completes.
- All LCD outputs are registered. in_ready is combinational from state and counter only, never from in_valid.
- A beat is accepted when in_valid & in_ready. Each accepted beat latches in_data, in_endofpacket and in_empty.
- States: IDLE, CS_SETUP, CMD_LOW, CMD_HIGH, WAIT_DATA, DATA_LOW, DATA_HIGH, CS_HOLD. One shared down-counter times each state.
- IDLE: in_ready=1.
  - Accepted beat with SOP: go to CS_SETUP; the beat's byte is held as pending data.
  - Accepted beat without SOP: dropped, proto_err pulses, stay IDLE.
- CS_SETUP: cs_n=0, dc=0, lcd_data=CMD_RAMWR for CS_SETUP_CYCLES, then CMD_LOW.
- CMD_LOW: wr_n=0 for WR_LOW_CYCLES, then CMD_HIGH.
- CMD_HIGH: wr_n=1 for WR_HIGH_CYCLES.
  - Pending beat is EOP with empty=1: go to CS_HOLD (command only, no data write).
  - Otherwise: go to DATA_LOW with dc=1 and lcd_data=pending byte.
- DATA_LOW: wr_n=0 for WR_LOW_CYCLES, then DATA_HIGH.
- DATA_HIGH: wr_n=1 for WR_HIGH_CYCLES.
  - Pending beat was EOP: go to CS_HOLD after the last cycle; in_ready=0 throughout.
  - Otherwise: in_ready=1 in the last DATA_HIGH cycle. A beat accepted there goes straight to DATA_LOW, so the sustained byte period is WR_LOW_CYCLES+WR_HIGH_CYCLES. With no beat, go to WAIT_DATA.
- WAIT_DATA: cs_n=0, wr_n=1, in_ready=1.
  - Accepted beat, no SOP, not (EOP & empty): go to DATA_LOW.
  - EOP with empty=1: go to CS_HOLD, no write.
  - Accepted beat with SOP (SOP mid-packet): proto_err pulses. Go to CMD_LOW (CS stays low, dc=0, data=CMD_RAMWR); the byte becomes pending.
- CS_HOLD: cs_n=0, wr_n=1 for 1 cycle, then IDLE with cs_n=1. in_ready=0.
- lcd_data and lcd_dc are stable for the whole LOW+HIGH window of each byte.
- Latency: SOP accepted at cycle T gives cs_n low at T+1 and the first wr_n low at T+1+CS_SETUP_CYCLES.

Decomposition:
- Package lcd_writer_pkg:
  - state enum;
  - CMD_RAMWR default;
  - localparam CNT_W = $clog2 of max(WR_LOW_CYCLES, WR_HIGH_CYCLES, CS_SETUP_CYCLES)+1.
- One sub-module, lcd_strobe_timer: loadable down-counter with load value and a done flag. The FSM instantiates it once.

Test Plan:
- Defaults; packet of 3 beats 0x11, 0x22, 0x33 (EOP on 0x33, empty=0), in_valid continuously high:
  - bus sees 0x2C with dc=0, then 0x11, 0x22, 0x33 with dc=1;
  - 4 wr_n low pulses, each 2 clocks;
  - cs_n low from T+1 for 1+16+1 cycles;
  - data bytes spaced exactly 4 clocks.
- Single-beat packet, SOP+EOP, empty=1: only 0x2C is written; 1 wr_n pulse; cs_n returns high; busy drops.
- Beat 0x55 without SOP while IDLE: proto_err pulses for 1 cycle; no cs_n activity; next SOP packet is written normally.
- SOP with 0xAA, then a second SOP beat 0xBB (no EOP between):
  - proto_err pulses;
  - bus shows 0x2C, 0xAA, 0x2C, 0xBB with no cs_n rise between.
- Source stalls 10 cycles after the first data byte: FSM sits in WAIT_DATA with cs_n=0, wr_n=1, in_ready=1; no spurious strobes.
- reset_n asserted during a DATA_LOW cycle: lcd_cs_n=1, lcd_wr_n=1, busy=0 immediately (asynchronously); the next packet after release begins with 0x2C.

Source files
------------

// File: rtl/lcd_writer_pkg.sv
// Shared types and constants for the 8080 LCD byte writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default RAMWR command, timer width helper.
package lcd_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_CMD_LOW,
      ST_CMD_HIGH,
      ST_WAIT_DATA,
      ST_DATA_LOW,
      ST_DATA_HIGH,
      ST_CS_HOLD
   } wr_state_t;

   localparam logic [7:0] CMD_RAMWR_DEF    = 8'h2C;
   localparam int         WR_LOW_DEF       = 2;
   localparam int         WR_HIGH_DEF      = 2;
   localparam int         CS_SETUP_DEF     = 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width that can hold the longest phase length of the strobe timer.
   function automatic int cnt_width(input int lo, input int hi, input int su);
      return $clog2(max3(lo, hi, su) + 1);
   endfunction

   localparam int CNT_W = cnt_width(WR_LOW_DEF, WR_HIGH_DEF, CS_SETUP_DEF);

endpackage

// File: rtl/lcd_strobe_timer.sv
// Loadable down-counter timing each phase of the 8080 write FSM.
// Latency: load takes effect next cycle; done is combinational from the count.
// Backpressure: none; counts freely until zero, then holds.
// Ports: clk, reset_n, load, load_val (phase length - 1), done (count == 0).
module lcd_strobe_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_8080_byte_writer.sv
// Avalon-ST byte sink -> 8080 parallel write burst (RAMWR command then data, one CS window).
// Latency: SOP accepted at T drives cs_n low at T+1, first wr_n low at T+1+CS_SETUP_CYCLES.
// Backpressure: in_ready only in IDLE, WAIT_DATA and the last DATA_HIGH cycle of a non-EOP byte.
// Ports: clk/reset_n; Avalon-ST sink in_*; LCD pins lcd_cs_n/dc/wr_n/rd_n/data; busy; proto_err pulse.
module lcd_8080_byte_writer
   import lcd_writer_pkg::*;
#(
   parameter int         WR_LOW_CYCLES   = WR_LOW_DEF,
   parameter int         WR_HIGH_CYCLES  = WR_HIGH_DEF,
   parameter int         CS_SETUP_CYCLES = CS_SETUP_DEF,
   parameter logic [7:0] CMD_RAMWR       = CMD_RAMWR_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_startofpacket,
   input  logic       in_endofpacket,
   input  logic       in_empty,
   output logic       lcd_cs_n,
   output logic       lcd_dc,
   output logic       lcd_wr_n,
   output logic       lcd_rd_n,
   output logic [7:0] lcd_data,
   output logic       busy,
   output logic       proto_err
);

   localparam int          CW       = cnt_width(WR_LOW_CYCLES, WR_HIGH_CYCLES, CS_SETUP_CYCLES);
   localparam logic [CW-1:0] LD_LOW   = CW'(WR_LOW_CYCLES - 1);
   localparam logic [CW-1:0] LD_HIGH  = CW'(WR_HIGH_CYCLES - 1);
   localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP_CYCLES - 1);

   wr_state_t     state_q, state_d;
   logic          tmr_done, tmr_load;
   logic [CW-1:0] tmr_val;
   logic          rdy, accept, err_d;
   logic [7:0]    byte_q, byte_d;
   logic          eop_q, empty_q;
   logic          cs_n_d, dc_d, wr_n_d;
   logic [7:0]    data_d;
   wr_state_t     beat_state;
   logic          beat_err;

   lcd_strobe_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Ready depends only on state and timer; gated so nothing is offered during reset.
   always_comb begin
      rdy = 1'b0;
      case (state_q)
         ST_IDLE, ST_WAIT_DATA: rdy = 1'b1;
         ST_DATA_HIGH:          rdy = tmr_done & ~eop_q;
         default:               rdy = 1'b0;
      endcase
   end

   assign in_ready = rdy & reset_n;
   assign accept   = in_valid & in_ready;
   assign byte_d   = accept ? in_data : byte_q;

   // Where a beat accepted inside an open burst leads: a fresh SOP restarts with a
   // new RAMWR under the same CS, an empty EOP closes without a write.
   always_comb begin
      beat_err   = 1'b0;
      beat_state = ST_DATA_LOW;
      if (in_startofpacket) begin
         beat_err   = 1'b1;
         beat_state = ST_CMD_LOW;
      end else if (in_endofpacket & in_empty) begin
         beat_state = ST_CS_HOLD;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_startofpacket) state_d = ST_CS_SETUP;
               else                  err_d   = 1'b1;
            end
         end
         ST_CS_SETUP:  if (tmr_done) state_d = ST_CMD_LOW;
         ST_CMD_LOW:   if (tmr_done) state_d = ST_CMD_HIGH;
         ST_CMD_HIGH:  if (tmr_done) state_d = (eop_q & empty_q) ? ST_CS_HOLD : ST_DATA_LOW;
         ST_DATA_LOW:  if (tmr_done) state_d = ST_DATA_HIGH;
         ST_DATA_HIGH: begin
            if (tmr_done) begin
               if (eop_q) begin
                  state_d = ST_CS_HOLD;
               end else if (accept) begin
                  state_d = beat_state;
                  err_d   = beat_err;
               end else begin
                  state_d = ST_WAIT_DATA;
               end
            end
         end
         ST_WAIT_DATA: begin
            if (accept) begin
               state_d = beat_state;
               err_d   = beat_err;
            end
         end
         ST_CS_HOLD:   state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Every transition reloads the timer with the length of the phase being entered.
   assign tmr_load = (state_d != state_q);

   always_comb begin
      tmr_val = '0;
      case (state_d)
         ST_CS_SETUP:               tmr_val = LD_SETUP;
         ST_CMD_LOW, ST_DATA_LOW:   tmr_val = LD_LOW;
         ST_CMD_HIGH, ST_DATA_HIGH: tmr_val = LD_HIGH;
         default:                   tmr_val = '0;
      endcase
   end

   // Pin values are decoded from the next state so the pins are plain registers
   // that change on the same edge as the state.
   always_comb begin
      cs_n_d = (state_d == ST_IDLE);
      wr_n_d = !((state_d == ST_CMD_LOW) || (state_d == ST_DATA_LOW));
      dc_d   = lcd_dc;
      data_d = lcd_data;
      case (state_d)
         ST_CS_SETUP, ST_CMD_LOW, ST_CMD_HIGH: begin
            dc_d   = 1'b0;
            data_d = CMD_RAMWR;
         end
         ST_DATA_LOW, ST_DATA_HIGH, ST_WAIT_DATA: begin
            dc_d   = 1'b1;
            data_d = byte_d;
         end
         ST_IDLE: begin
            dc_d   = 1'b1;
            data_d = 8'h00;
         end
         default: begin
            dc_d   = lcd_dc;
            data_d = lcd_data;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         byte_q    <= 8'h00;
         eop_q     <= 1'b0;
         empty_q   <= 1'b0;
         lcd_cs_n  <= 1'b1;
         lcd_dc    <= 1'b1;
         lcd_wr_n  <= 1'b1;
         lcd_data  <= 8'h00;
         proto_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         lcd_cs_n  <= cs_n_d;
         lcd_dc    <= dc_d;
         lcd_wr_n  <= wr_n_d;
         lcd_data  <= data_d;
         proto_err <= err_d;
         if (accept) begin
            byte_q  <= in_data;
            eop_q   <= in_endofpacket;
            empty_q <= in_empty;
         end
      end
   end

   assign lcd_rd_n = 1'b1;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_8080_byte_writer.sv
// Self-checking bench for lcd_8080_byte_writer: directed scenarios plus random packets.
// A packet-level model predicts the command/data writes and protocol-error count.
// A pin monitor reconstructs writes from wr_n rising edges while cs_n is low.
module tb_lcd_8080_byte_writer;

   localparam int         WR_LOW   = 2;
   localparam int         WR_HIGH  = 2;
   localparam int         CS_SETUP = 1;
   localparam logic [7:0] CMD      = 8'h2C;

   logic       clk;
   logic       reset_n;
   logic       in_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_startofpacket;
   logic       in_endofpacket;
   logic       in_empty;
   logic       lcd_cs_n;
   logic       lcd_dc;
   logic       lcd_wr_n;
   logic       lcd_rd_n;
   logic [7:0] lcd_data;
   logic       busy;
   logic       proto_err;

   lcd_8080_byte_writer #(
      .WR_LOW_CYCLES   (WR_LOW),
      .WR_HIGH_CYCLES  (WR_HIGH),
      .CS_SETUP_CYCLES (CS_SETUP),
      .CMD_RAMWR       (CMD)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_ready         (in_ready),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_startofpacket (in_startofpacket),
      .in_endofpacket   (in_endofpacket),
      .in_empty         (in_empty),
      .lcd_cs_n         (lcd_cs_n),
      .lcd_dc           (lcd_dc),
      .lcd_wr_n         (lcd_wr_n),
      .lcd_rd_n         (lcd_rd_n),
      .lcd_data         (lcd_data),
      .busy             (busy),
      .proto_err        (proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model: packet rules -> expected pin writes ----------------
   logic [8:0] exp_q[$];   // {dc, byte}
   int         exp_err = 0;
   bit         in_pkt  = 0;

   task automatic model_beat(input logic [7:0] d, input bit sop, input bit eop, input bit emp);
      if (!in_pkt && !sop) begin
         exp_err++;
      end else begin
         if (sop && in_pkt) exp_err++;
         if (sop) exp_q.push_back({1'b0, CMD});
         if (!(eop && emp)) exp_q.push_back({1'b1, d});
         in_pkt = !eop;
      end
   endtask

   // ---------------- pin monitor ----------------
   bit         prev_wr = 1, prev_cs = 1, prev_err = 0;
   int         low_cnt = 0, err_run = 0, proto_seen = 0;
   bit         lo_dc, unstable;
   logic [7:0] lo_data;
   int         cs_falls = 0, cs_rises = 0, cs_run = 0, last_cs_run = 0, cs_fall_cyc = 0;
   int         fall_cyc[$];
   logic [8:0] exp_w;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!lcd_wr_n) begin
            if (prev_wr) begin
               low_cnt  = 0;
               lo_dc    = lcd_dc;
               lo_data  = lcd_data;
               unstable = 0;
               fall_cyc.push_back(cyc);
            end
            low_cnt++;
            if (lcd_dc !== lo_dc || lcd_data !== lo_data) unstable = 1;
         end else if (!prev_wr && !lcd_cs_n) begin
            check("wr_low_width", 32'(low_cnt), 32'(WR_LOW));
            check("bus_stable", 32'(unstable), 32'd0);
            check("write_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               exp_w = exp_q.pop_front();
               check("write", 32'({lo_dc, lo_data}), 32'(exp_w));
            end
         end
         if (!lcd_cs_n) begin
            if (prev_cs) begin
               cs_falls++;
               cs_fall_cyc = cyc;
               cs_run      = 0;
            end
            cs_run++;
         end else if (!prev_cs) begin
            cs_rises++;
            last_cs_run = cs_run;
         end
         if (proto_err) begin
            if (!prev_err) err_run = 0;
            err_run++;
         end else if (prev_err) begin
            proto_seen++;
            check("proto_width", 32'(err_run), 32'd1);
         end
         prev_wr  = lcd_wr_n;
         prev_cs  = lcd_cs_n;
         prev_err = proto_err;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- driver helpers (called at negedge) ----------------
   task automatic send(input logic [7:0] d, input bit sop, input bit eop, input bit emp);
      bit ok = 0;
      in_data          = d;
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_empty         = emp;
      in_valid         = 1'b1;
      for (int t = 0; t < 300; t++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check("beat_accepted", 32'(ok), 32'd1);
      @(negedge clk);
      if (ok) model_beat(d, sop, eop, emp);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      in_valid = 1'b0;
      for (int t = 0; t < 500; t++) begin
         if (!busy) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check("idle_reached", 32'(ok), 32'd1);
      @(negedge clk);
   endtask

   // ---------------- main sequence ----------------
   int  r0, e0, f0, nf, bad, len;
   bit  found, sop, eop, emp;

   initial begin
      reset_n          = 1'b0;
      in_valid         = 1'b0;
      in_data          = 8'h00;
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      in_empty         = 1'b0;
      #12;
      check("rst_cs_n",      32'(lcd_cs_n),  32'd1);
      check("rst_dc",        32'(lcd_dc),    32'd1);
      check("rst_wr_n",      32'(lcd_wr_n),  32'd1);
      check("rst_rd_n",      32'(lcd_rd_n),  32'd1);
      check("rst_data",      32'(lcd_data),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_proto_err", 32'(proto_err), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Three-byte packet with continuous valid.
      fall_cyc.delete();
      r0 = cs_rises;
      send(8'h11, 1, 0, 0);
      check("cs_low_after_sop", 32'(lcd_cs_n), 32'd0);
      send(8'h22, 0, 0, 0);
      send(8'h33, 0, 1, 0);
      wait_idle();
      check("burst_cs_len",    32'(last_cs_run), 32'(CS_SETUP + 4 * (WR_LOW + WR_HIGH) + 1));
      check("burst_cs_rises",  32'(cs_rises - r0), 32'd1);
      check("burst_strobes",   32'(fall_cyc.size()), 32'd4);
      if (fall_cyc.size() == 4) begin
         check("first_wr_latency", 32'(fall_cyc[0] - cs_fall_cyc), 32'(CS_SETUP));
         for (int i = 1; i < 4; i++)
            check("byte_period", 32'(fall_cyc[i] - fall_cyc[i-1]), 32'(WR_LOW + WR_HIGH));
      end

      // Single beat, SOP+EOP, empty: command only.
      fall_cyc.delete();
      send(8'h9C, 1, 1, 1);
      wait_idle();
      check("empty_pkt_strobes", 32'(fall_cyc.size()), 32'd1);
      check("empty_pkt_cs_n",    32'(lcd_cs_n), 32'd1);
      check("empty_pkt_busy",    32'(busy), 32'd0);

      // Stray beat without SOP while idle.
      e0 = proto_seen;
      f0 = cs_falls;
      send(8'h55, 0, 0, 0);
      idle(4);
      check("stray_proto_err", 32'(proto_seen - e0), 32'd1);
      check("stray_no_cs",     32'(cs_falls - f0), 32'd0);
      check("stray_busy",      32'(busy), 32'd0);
      send(8'h66, 1, 0, 0);
      send(8'h67, 0, 1, 0);
      wait_idle();

      // SOP arriving mid-packet.
      r0 = cs_rises;
      e0 = proto_seen;
      send(8'hAA, 1, 0, 0);
      send(8'hBB, 1, 1, 0);
      wait_idle();
      check("midsop_cs_rises",  32'(cs_rises - r0), 32'd1);
      check("midsop_proto_err", 32'(proto_seen - e0), 32'd1);

      // Source stall after the first data byte.
      send(8'h01, 1, 0, 0);
      idle(12);
      nf  = fall_cyc.size();
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (lcd_cs_n !== 1'b0 || lcd_wr_n !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b1) bad++;
      end
      check("stall_wait_cycles_bad", 32'(bad), 32'd0);
      check("stall_strobes", 32'(fall_cyc.size() - nf), 32'd0);
      send(8'h02, 0, 1, 0);
      wait_idle();

      // Reset during a data low phase.
      send(8'h77, 1, 0, 0);
      in_valid = 1'b0;
      found = 0;
      for (int t = 0; t < 50; t++) begin
         if (!lcd_wr_n && lcd_dc) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("reached_data_low", 32'(found), 32'd1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_cs_n",     32'(lcd_cs_n), 32'd1);
      check("abort_wr_n",     32'(lcd_wr_n), 32'd1);
      check("abort_busy",     32'(busy), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_pending_writes", 32'(exp_q.size()), 32'd1);
      exp_q.delete();
      in_pkt = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send(8'h78, 1, 1, 0);
      wait_idle();

      // Random packets with gaps, empty EOPs, stray beats and mid-packet SOPs.
      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 5) == 0) send(8'($urandom), 0, 0, 0);
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            sop = (i == 0) || ($urandom_range(0, 7) == 0);
            eop = (i == len - 1);
            emp = eop && ($urandom_range(0, 2) == 0);
            send(8'($urandom), sop, eop, emp);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
         end
      end
      wait_idle();
      idle(5);

      check("writes_left",     32'(exp_q.size()), 32'd0);
      check("proto_err_total", 32'(proto_seen), 32'(exp_err));
      check("final_rd_n",      32'(lcd_rd_n), 32'd1);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
